deserializer: RTL and testbench

Receiving end of the serial link driven by the `serializer` block. Collects MSB-first bits qualified by a valid strobe and reassembles them into a left-aligned 16-bit word. Emits the word with its bit count as `data_mod_o`, using the same encoding the serializer accepts, and pulses a one-cycle valid. Sits directly after the serial line, feeding the parallel datapath.

---
 rtl/deserializer_pkg.sv | 22 ++
 rtl/deserializer_if.sv | 42 ++++
 rtl/deserializer.sv | 133 +++++++++++++
 tb/tb_deserializer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/deserializer_pkg.sv
// ============================================================================
// Module   : deserializer_pkg
// Purpose  : Shared widths, defaults and state type for the serial-link receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package deserializer_pkg;

    localparam int DATA_W          = 16;
    localparam int MOD_W           = 4;
    localparam int CNT_W           = 5;
    localparam int MIN_LEN_DEFAULT = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/deserializer_if.sv
// ============================================================================
// Module   : deserializer_if
// Purpose  : Serial input and parallel output bundle of the deserializer.
//            DESERIALIZER_DROP_CNT_EN adds the runt drop counter output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface deserializer_if;
    import deserializer_pkg::*;

    logic               ser_data_i;
    logic               ser_data_val_i;
    logic [DATA_W-1:0]  data_o;
    logic [MOD_W-1:0]   data_mod_o;
    logic               data_val_o;
    logic               busy_o;
`ifdef DESERIALIZER_DROP_CNT_EN
    logic [15:0]        drop_cnt_o;

    modport slave (
        input  ser_data_i, ser_data_val_i,
        output data_o, data_mod_o, data_val_o, busy_o, drop_cnt_o
    );
    modport master (
        output ser_data_i, ser_data_val_i,
        input  data_o, data_mod_o, data_val_o, busy_o, drop_cnt_o
    );
`else
    modport slave (
        input  ser_data_i, ser_data_val_i,
        output data_o, data_mod_o, data_val_o, busy_o
    );
    modport master (
        output ser_data_i, ser_data_val_i,
        input  data_o, data_mod_o, data_val_o, busy_o
    );
`endif

endinterface

`default_nettype wire

// File: rtl/deserializer.sv
// ============================================================================
// Module   : deserializer
// Purpose  : Reassembles MSB-first serial frames into left-aligned 16-bit words.
//            Optional macro DESERIALIZER_DROP_CNT_EN adds a saturating runt counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module deserializer
    import deserializer_pkg::*;
#(
    parameter int DATA_W  = deserializer_pkg::DATA_W,
    parameter int MIN_LEN = MIN_LEN_DEFAULT
) (
    input  wire logic          clk_i,
    input  wire logic          arst_n_i,
    deserializer_if.slave      bus
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [MOD_W-1:0]   mod_q, mod_d;
    logic               val_q, val_d;

    logic               w_take_last;
    logic               w_end_short;
    logic               w_runt;
    logic [3:0]         w_bit_idx;

    assign w_take_last = (state_q == RECV) && bus.ser_data_val_i
                         && (cnt_q == CNT_W'(DATA_W - 1));
    assign w_end_short = (state_q == RECV) && !bus.ser_data_val_i;
    assign w_runt      = w_end_short && (cnt_q < CNT_W'(MIN_LEN));
    assign w_bit_idx   = 4'(DATA_W - 1) - cnt_q[3:0];

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            mod_q   <= '0;
            val_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            mod_q   <= mod_d;
            val_q   <= val_d;
        end
    end

    // A new frame always starts from a cleared register so untransmitted LSBs read as zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (bus.ser_data_val_i) begin
                    state_d = RECV;
                    cnt_d   = CNT_W'(1);
                    shift_d = {bus.ser_data_i, {(DATA_W-1){1'b0}}};
                end
            end
            RECV: begin
                if (bus.ser_data_val_i) begin
                    shift_d[w_bit_idx] = bus.ser_data_i;
                    cnt_d              = cnt_q + CNT_W'(1);
                    if (w_take_last) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A full frame reports mod 0; the emitted word includes the bit sampled this edge.
    always_comb begin
        data_d = data_q;
        mod_d  = mod_q;
        val_d  = 1'b0;
        if (w_take_last) begin
            data_d = shift_d;
            mod_d  = '0;
            val_d  = 1'b1;
        end else if (w_end_short && !w_runt) begin
            data_d = shift_q;
            mod_d  = cnt_q[MOD_W-1:0];
            val_d  = 1'b1;
        end
    end

    assign bus.data_o     = data_q;
    assign bus.data_mod_o = mod_q;
    assign bus.data_val_o = val_q;
    assign bus.busy_o     = (state_q == RECV);

`ifdef DESERIALIZER_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (w_runt && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.drop_cnt_o = drop_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_deserializer.sv
// ============================================================================
// Module   : tb_deserializer
// Purpose  : Self-checking bench for deserializer: vector table, corner sequences,
//            and random frames against a word/mod reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_deserializer;

    localparam int MIN_LEN = 3;
    localparam int N_RAND  = 1000;

    typedef struct {
        logic [15:0] word;
        int          len;
        int          pulses;
        logic [15:0] data;
        logic [3:0]  mod;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  mod;
    } exp_t;

    logic clk;
    logic arst_n;

    int   total;
    int   bad;
    int   pulse_cnt;
    bit   sb_on;
    int   drop_exp;
    exp_t exp_q[$];
    exp_t mon_e;
    vec_t tbl[8];

    deserializer_if bus();

    deserializer dut (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic send_bits(input logic [15:0] w, input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            bus.ser_data_i     = w[15-i];
            bus.ser_data_val_i = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.ser_data_i     = 1'($urandom);
            bus.ser_data_val_i = 1'b0;
        end
    endtask

    function automatic logic [15:0] keep_msbs(input logic [15:0] w, input int len);
        logic [15:0] ones;
        ones = 16'hFFFF;
        return w & ~(ones >> len);
    endfunction

    // Every output pulse is counted; with the scoreboard on it must match the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (bus.data_val_o === 1'b1) begin
            pulse_cnt++;
            if (sb_on) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse actual=%h/%0d required=none", bus.data_o, bus.data_mod_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pulse_data", 32'(bus.data_o), 32'(mon_e.data));
                    chk("pulse_mod", 32'(bus.data_mod_o), 32'(mon_e.mod));
                end
            end
        end
    end

    initial begin
        logic [15:0] w;
        int          m;
        int          len;
        int          p0;

        total = 0; bad = 0; pulse_cnt = 0; sb_on = 1'b0; drop_exp = 0;
        bus.ser_data_i     = 1'b0;
        bus.ser_data_val_i = 1'b0;

        tbl[0] = '{16'hA5C3, 16, 1, 16'hA5C3, 4'd0};
        tbl[1] = '{16'hB7FF,  5, 1, 16'hB000, 4'd5};
        tbl[2] = '{16'hDFFF,  2, 0, 16'hB000, 4'd5};
        tbl[3] = '{16'h5FFF,  3, 1, 16'h4000, 4'd3};
        tbl[4] = '{16'h0001, 16, 1, 16'h0001, 4'd0};
        tbl[5] = '{16'h8000,  1, 0, 16'h0001, 4'd0};
        tbl[6] = '{16'h123F, 12, 1, 16'h1230, 4'd12};
        tbl[7] = '{16'hFFFF, 15, 1, 16'hFFFE, 4'd15};

        arst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_data", 32'(bus.data_o), 32'h0);
        chk("rst_mod", 32'(bus.data_mod_o), 32'h0);
        chk("rst_val", 32'(bus.data_val_o), 32'h0);
        chk("rst_busy", 32'(bus.busy_o), 32'h0);
`ifdef DESERIALIZER_DROP_CNT_EN
        chk("rst_drop", 32'(bus.drop_cnt_o), 32'h0);
`endif
        arst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            p0 = pulse_cnt;
            send_bits(tbl[k].word, tbl[k].len);
            idle(1);
            @(posedge clk);
            #2;
            if (tbl[k].len < MIN_LEN) drop_exp++;
            chk("tbl_pulses", 32'(pulse_cnt - p0), 32'(tbl[k].pulses));
            chk("tbl_data", 32'(bus.data_o), 32'(tbl[k].data));
            chk("tbl_mod", 32'(bus.data_mod_o), 32'(tbl[k].mod));
            chk("tbl_busy", 32'(bus.busy_o), 32'h0);
`ifdef DESERIALIZER_DROP_CNT_EN
            chk("tbl_drop", 32'(bus.drop_cnt_o), 32'(drop_exp));
`endif
        end

        // Full frame immediately followed by a short frame, no gap between them.
        sb_on = 1'b1;
        exp_q.push_back('{16'hFFFF, 4'd0});
        exp_q.push_back('{16'h4000, 4'd3});
        send_bits(16'hFFFF, 16);
        send_bits(16'h4000, 3);
        @(posedge clk);
        #1;
        chk("b2b_busy", 32'(bus.busy_o), 32'h1);
        idle(3);
        chk("b2b_drained", 32'(exp_q.size()), 32'h0);

        // Reset in the middle of a frame, then a clean 4-bit frame.
        send_bits(16'hDEAD, 7);
        @(negedge clk);
        arst_n = 1'b0;
        bus.ser_data_val_i = 1'b0;
        #1;
        chk("mid_rst_data", 32'(bus.data_o), 32'h0);
        chk("mid_rst_mod", 32'(bus.data_mod_o), 32'h0);
        chk("mid_rst_busy", 32'(bus.busy_o), 32'h0);
        drop_exp = 0;
`ifdef DESERIALIZER_DROP_CNT_EN
        chk("mid_rst_drop", 32'(bus.drop_cnt_o), 32'h0);
`endif
        @(negedge clk);
        arst_n = 1'b1;
        exp_q.push_back('{16'h9000, 4'd4});
        send_bits(16'h9000, 4);
        idle(3);
        chk("rst_frame_drained", 32'(exp_q.size()), 32'h0);
        chk("rst_frame_data", 32'(bus.data_o), 32'h9000);

        // Random frames: word truncated to its first len bits, runts never emitted.
        for (int n = 0; n < N_RAND; n++) begin
            w   = 16'($urandom);
            m   = int'($urandom_range(0, 15));
            len = (m == 0) ? 16 : m;
            if (len >= MIN_LEN) begin
                exp_q.push_back('{keep_msbs(w, len), 4'(m)});
            end else begin
                drop_exp++;
            end
            send_bits(w, len);
            if (len == 16) idle(int'($urandom_range(0, 2)));
            else           idle(int'($urandom_range(1, 2)));
        end
        idle(3);
        chk("rand_drained", 32'(exp_q.size()), 32'h0);
`ifdef DESERIALIZER_DROP_CNT_EN
        chk("rand_drop", 32'(bus.drop_cnt_o), 32'(drop_exp));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
